// File: rtl/hid_uart_pkg.sv
// Shared definitions for the hid_uart_rx console receiver: FSM state encoding
// and the baud divider / counter-width helpers.
package hid_uart_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5
  } rx_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int calc_cnt_w(input int div);
    return $clog2(div) + 1;
  endfunction

  localparam int DEFAULT_DIV   = calc_div(12000000, 115200);
  localparam int DEFAULT_CNT_W = calc_cnt_w(DEFAULT_DIV);

endpackage

// File: rtl/hid_uart_fifo.sv
// Small synchronous byte FIFO with a registered head byte; reports pushes that
// were dropped because the FIFO was full and nothing was popped that cycle.
module hid_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [7:0]  r_data;

  logic [AW:0] w_count;
  logic [AW:0] w_rptr_nx;
  logic        w_empty;
  logic        w_full;
  logic        w_do_pop;
  logic        w_do_push;

  assign w_count   = r_wptr - r_rptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == CNT_FULL);
  assign w_rptr_nx = r_rptr + CNT_ONE;
  assign w_do_pop  = i_pop && !w_empty;
  // A pop frees the slot in the same cycle, so full + push + pop still stores.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_data <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + CNT_ONE;
      if (w_do_pop) begin
        r_rptr <= w_rptr_nx;
        if (w_count != CNT_ONE) r_data <= r_mem[w_rptr_nx[AW-1:0]];
        else if (w_do_push)     r_data <= i_push_data;
      end else if (w_do_push && w_empty) begin
        r_data <= i_push_data;
      end
    end
  end

  assign o_data  = r_data;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_drop  = i_push && !w_do_push;

endmodule

// File: rtl/hid_uart_rx.sv
// UART 8N1 console receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// byte FIFO. Define HID_UART_RX_PARITY_EN for 8E1 frames with a parity_err flag.
module hid_uart_rx
  import hid_uart_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
`ifdef HID_UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int DIV  = calc_div(CLK_HZ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = calc_cnt_w(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef HID_UART_RX_PARITY_EN
  localparam rx_state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_t ST_AFTER_DATA = ST_STOP;
`endif

  logic          r_sync1;
  logic          r_sync2;
  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_push;
  logic          r_frame_err;
  logic          r_overrun;
`ifdef HID_UART_RX_PARITY_EN
  logic          r_par_bit;
  logic          r_par_fail;
  logic          r_parity_err;
  logic          w_par_ok;
`endif

  logic          w_rx;
  logic          w_empty;
  logic          w_full;
  logic          w_drop;
  logic          w_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;
`ifdef HID_UART_RX_PARITY_EN
  assign w_par_ok = ~^{r_shift, r_par_bit};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_WAIT_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef HID_UART_RX_PARITY_EN
      r_par_bit   <= 1'b0;
      r_par_fail  <= 1'b0;
`endif
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef HID_UART_RX_PARITY_EN
      r_par_fail  <= 1'b0;
`endif
      case (r_state)
        ST_WAIT_IDLE: begin
          if (!w_rx) r_cnt <= '0;
          else if (r_cnt == DIV_M1) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else r_cnt <= r_cnt + CNT_ONE;
        end
        ST_IDLE: begin
          if (!w_rx) begin
            r_cnt   <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx ? ST_IDLE : ST_DATA;
          end else r_cnt <= r_cnt + CNT_ONE;
        end
        ST_DATA: begin
          if (r_cnt == DIV_M1) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= ST_AFTER_DATA;
          end else r_cnt <= r_cnt + CNT_ONE;
        end
`ifdef HID_UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == DIV_M1) begin
            r_cnt     <= '0;
            r_par_bit <= w_rx;
            r_state   <= ST_STOP;
          end else r_cnt <= r_cnt + CNT_ONE;
        end
`endif
        ST_STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (r_cnt == DIV_M1) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_state <= ST_IDLE;
`ifdef HID_UART_RX_PARITY_EN
              if (w_par_ok) r_push <= 1'b1;
              else          r_par_fail <= 1'b1;
`else
              r_push <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_IDLE;
            end
          end else r_cnt <= r_cnt + CNT_ONE;
        end
        default: r_state <= ST_WAIT_IDLE;
      endcase
    end
  end

  assign w_pop = out_valid && out_ready;

  hid_uart_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (resetn),
    .i_push      (r_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_data      (out_data),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_drop      (w_drop)
  );

  // Sticky error flags: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overrun <= 1'b0;
`ifdef HID_UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_drop)       r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
`ifdef HID_UART_RX_PARITY_EN
      if (r_par_fail)   r_parity_err <= 1'b1;
      else if (clr_err) r_parity_err <= 1'b0;
`endif
    end
  end

  assign out_valid = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);
`ifdef HID_UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule
